cla_mp_sequencer: RTL
=====================

# cla_mp_sequencer

Multi-precision adder sequencer. It computes the (N*WORDS+1)-bit sum of two N*WORDS-bit operands using a single CLA_nbit #(N) instance, processing one N-bit word per pass from least to most significant. CLA_nbit has no carry-in, so the inter-word carry is folded in by a second "carry pass" through the same adder. The block sits between a register-mapped operand source and any consumer of wide sums, with a start/busy/done handshake.

## Interface
- N, default 8: word width; width of the CLA_nbit instance.
- WORDS, default 4: number of words per operand; must be ≥ 1.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE or DONE.
- a_in  input  N*WORDS  operand A; latched when start is accepted.
- b_in  input  N*WORDS  operand B; latched when start is accepted.
- busy  output  1  high in ADD and CARRY states.
- done  output  1  single-cycle pulse in DONE state.
- sum_out  output  N*WORDS+1  result; bit N*WORDS is the final carry; held from DONE until the next accepted start.

## Operation
- Exactly one CLA_nbit #(N) instance; no other adder in the datapath. Operand mux and result capture are registered.
- State registers: state, word index idx (0..WORDS-1), carry register ci, partial register p (N+1 bits), operand registers a_r and b_r, result register.
- IDLE: busy=0, done=0. If start=1, latch a_in and b_in, set ci=0 and idx=0, clear the result register, and go to ADD.
- ADD: adder inputs are a_r word idx and b_r word idx. Capture p = adder Sum (N+1 bits).
  - If CARRY is required (see Configuration), go to CARRY.
  - Otherwise, write p[N-1:0] to result word idx, set ci = p[N], and advance.
- CARRY: adder inputs are p[N-1:0] and a zero-extended ci. Write Sum[N-1:0] to result word idx. Set ci = p[N] | Sum[N], then advance.
  - p[N] and Sum[N] are never both 1, so the OR is exact.
- Advance:
  - If idx < WORDS-1: idx++, go to ADD.
  - Otherwise: result bit N*WORDS = new ci, go to DONE.
- DONE: done=1, busy=0, sum_out valid.
  - If start=1, accept a new operation exactly as in IDLE, which allows back-to-back operations.
  - Otherwise go to IDLE.
- start during ADD or CARRY is ignored; the latched operands are unaffected.
- Arithmetic is unsigned, modulo 2^(N*WORDS+1); it never overflows.
- sum_out is driven from the result register. Its intermediate content is not guaranteed while busy=1.

## Timing
- Reset: state=IDLE; busy=0, done=0, sum_out=0; idx, ci and p are cleared.
- Reset mid-operation: the block returns to IDLE on the next edge, and the operation is discarded with no done pulse.
- Let edge 0 be the edge at which start is accepted.
  - busy rises after edge 0.
  - done is high for exactly one cycle, immediately after the last ADD/CARRY cycle.
- Latency without CLA_MPS_SKIP_EN: 2*WORDS busy cycles; done is high in cycle 2*WORDS+1, independent of the data.
- Latency with CLA_MPS_SKIP_EN: WORDS + K busy cycles, where K is the number of words entered with ci=1. Word 0 never needs CARRY.
- WORDS=1: a single ADD cycle (plus one CARRY cycle without the macro), then DONE.

## Configuration
- CLA_MPS_SKIP_EN defined: CARRY runs only when ci=1 at ADD. The latency is data-dependent, with a minimum of WORDS+1 cycles to done.
- CLA_MPS_SKIP_EN undefined: CARRY always runs, adding ci even when ci=0. Latency is fixed at 2*WORDS+1 cycles to done.
- The sum_out value is identical in both builds.

## Test plan
All cases use N=8, WORDS=4, with start pulsed at edge 0.
1. A=0x00000001, B=0x00000002 -> sum_out=0x0_00000003.
   - Done in cycle 5 with the macro, cycle 9 without.
2. A=0xFFFFFFFF, B=0x00000001 -> sum_out=0x1_00000000.
   - Carry ripples through all words, so done is in cycle 8 with the macro, cycle 9 without.
3. A=B=0xFFFFFFFF -> sum_out=0x1_FFFFFFFE.
   - Also run 200 random operand pairs checked against a reference sum.
4. start=1 with new operands while busy -> ignored; the first result is unchanged.
   - start held high in the DONE cycle -> the second operation begins immediately, with exactly one done pulse per operation.
5. rst asserted in cycle 3 of an operation -> next cycle busy=0, done=0, sum_out=0.
   - A following start with A=0x12345678, B=0x87654321 -> sum_out=0x0_99999999.

Source files
------------

// File: rtl/cla_mp_sequencer.sv
// rtl/cla_mp_sequencer.sv - multi-precision adder sequenced through one CLA_nbit instance
// CLA_MPS_SKIP_EN: skip the carry pass for words entered with no incoming carry.

module cla_mp_sequencer #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N*WORDS-1:0] a_in,
    input  logic [N*WORDS-1:0] b_in,
    output logic               busy,
    output logic               done,
    output logic [N*WORDS:0]   sum_out
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_CARRY, S_DONE} state_t;

    state_t             state, next_state;
    logic [IW-1:0]      idx;
    logic               ci;
    logic [N:0]         p;
    logic [N*WORDS-1:0] a_r, b_r;
    logic [N*WORDS:0]   result;

    logic [N-1:0]       cla_a, cla_b;
    logic [N:0]         cla_sum;
    logic               accept, need_carry, last_word, word_write, new_ci;

`ifdef CLA_MPS_SKIP_EN
    assign need_carry = ci;
`else
    assign need_carry = 1'b1;
`endif

    assign last_word = (idx == LAST_IDX);
    assign sum_out   = result;

    CLA_nbit #(.N(N)) u_cla (
        .a   (cla_a),
        .b   (cla_b),
        .Sum (cla_sum)
    );

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        word_write = 1'b0;
        cla_a      = a_r[idx*N +: N];
        cla_b      = b_r[idx*N +: N];
        new_ci     = cla_sum[N];
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = S_ADD;
                end
            end
            S_ADD: begin
                busy = 1'b1;
                if (need_carry) begin
                    next_state = S_CARRY;
                end else begin
                    word_write = 1'b1;
                    next_state = last_word ? S_DONE : S_ADD;
                end
            end
            S_CARRY: begin
                busy       = 1'b1;
                cla_a      = p[N-1:0];
                cla_b      = N'(ci);
                word_write = 1'b1;
                // p[N] and the carry-pass carry are mutually exclusive, so OR is exact
                new_ci     = p[N] | cla_sum[N];
                next_state = last_word ? S_DONE : S_ADD;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    next_state = S_ADD;
                end else begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            idx    <= '0;
            ci     <= 1'b0;
            p      <= '0;
            a_r    <= '0;
            b_r    <= '0;
            result <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                a_r    <= a_in;
                b_r    <= b_in;
                ci     <= 1'b0;
                idx    <= '0;
                result <= '0;
            end else begin
                if (state == S_ADD) begin
                    p <= cla_sum;
                end
                if (word_write) begin
                    result[idx*N +: N] <= cla_sum[N-1:0];
                    ci                 <= new_ci;
                    if (last_word) begin
                        result[N*WORDS] <= new_ci;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// Carry-lookahead adder without carry-in; every carry is a flat generate/propagate term.
module CLA_nbit #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N:0]   Sum
);

    logic [N-1:0] g, pr;
    logic [N:0]   c;
    logic         t;

    always_comb begin
        g = a & b;
        pr = a ^ b;
        c = '0;
        t = 1'b0;
        for (int i = 1; i <= N; i++) begin
            for (int j = 0; j < i; j++) begin
                t = g[j];
                for (int k = j + 1; k < i; k++) begin
                    t = t & pr[k];
                end
                c[i] = c[i] | t;
            end
        end
        Sum = {c[N], pr ^ c[N-1:0]};
    end

endmodule
